// File: rtl/mips_bus_pkg.sv
// Shared types for the two-master memory port arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int ARB_CNT_W = 8;

    // Run-length counter stops at all-ones so a lone master never wraps it.
    function automatic logic [ARB_CNT_W-1:0] cnt_sat_inc(input logic [ARB_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Avalon-MM bus bundle; master modport is the requester side, slave modport the responder side.
interface mips_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Round-robin two-master arbiter onto one Avalon-MM slave; 1-cycle grant latency from idle,
// grant held through waitrequest stalls and capped at BURST_MAX completions while the peer waits.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_bus_arbiter_if.slave  m0,
    mips_bus_arbiter_if.slave  m1,
    mips_bus_arbiter_if.master s,
    output logic [1:0]         grant
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [ARB_CNT_W-1:0]   r_cnt;
    logic [ARB_CNT_W-1:0]   w_cnt_nxt;
    logic                   r_last;
    logic                   w_last_nxt;

    logic                   w_req0;
    logic                   w_req1;
    logic                   w_quota_hit;

    logic                   w_m0_sel;
    logic [ADDR_W-1:0]      w_m0_addr;
    logic                   w_m0_rd;
    logic                   w_m0_wr;
    logic [DATA_W-1:0]      w_m0_wd;
    logic [DATA_W/8-1:0]    w_m0_be;

    logic                   w_m1_sel;
    logic [ADDR_W-1:0]      w_m1_addr;
    logic                   w_m1_rd;
    logic                   w_m1_wr;
    logic [DATA_W-1:0]      w_m1_wd;
    logic [DATA_W/8-1:0]    w_m1_be;

    assign w_req0      = m0.read | m0.write;
    assign w_req1      = m1.read | m1.write;
    // Evaluated in 32-bit so a saturated counter still trips the cap.
    assign w_quota_hit = (int'(r_cnt) + 1) >= BURST_MAX;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_req0 && w_req1) begin
                    w_state_nxt = r_last ? GNT0 : GNT1;
                end else if (w_req0) begin
                    w_state_nxt = GNT0;
                end else if (w_req1) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!w_req0) begin
                    w_state_nxt = w_req1 ? GNT1 : IDLE;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = 1'b0;
                end else if (!s.waitrequest) begin
                    if (w_req1 && w_quota_hit) begin
                        w_state_nxt = GNT1;
                        w_cnt_nxt   = '0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = cnt_sat_inc(r_cnt);
                    end
                end
            end
            GNT1: begin
                if (!w_req1) begin
                    w_state_nxt = w_req0 ? GNT0 : IDLE;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = 1'b1;
                end else if (!s.waitrequest) begin
                    if (w_req0 && w_quota_hit) begin
                        w_state_nxt = GNT0;
                        w_cnt_nxt   = '0;
                        w_last_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = cnt_sat_inc(r_cnt);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Each master contributes a masked copy of its request; the slave sees the OR.
    always_comb begin
        w_m0_sel        = (r_state == GNT0);
        w_m0_addr       = w_m0_sel ? m0.address    : '0;
        w_m0_rd         = w_m0_sel & m0.read;
        w_m0_wr         = w_m0_sel & m0.write;
        w_m0_wd         = w_m0_sel ? m0.writedata  : '0;
        w_m0_be         = w_m0_sel ? m0.byteenable : '0;
        m0.waitrequest  = w_m0_sel ? s.waitrequest : 1'b1;
    end

    always_comb begin
        w_m1_sel        = (r_state == GNT1);
        w_m1_addr       = w_m1_sel ? m1.address    : '0;
        w_m1_rd         = w_m1_sel & m1.read;
        w_m1_wr         = w_m1_sel & m1.write;
        w_m1_wd         = w_m1_sel ? m1.writedata  : '0;
        w_m1_be         = w_m1_sel ? m1.byteenable : '0;
        m1.waitrequest  = w_m1_sel ? s.waitrequest : 1'b1;
    end

    assign s.address    = w_m0_addr | w_m1_addr;
    assign s.read       = w_m0_rd   | w_m1_rd;
    assign s.write      = w_m0_wr   | w_m1_wr;
    assign s.writedata  = w_m0_wd   | w_m1_wd;
    assign s.byteenable = w_m0_be   | w_m1_be;

    assign m0.readdata  = s.readdata;
    assign m1.readdata  = s.readdata;

    assign grant        = {w_m1_sel, w_m0_sel};

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: vector table, directed corner sequences, random run vs reference model.
module tb_mips_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] m_addr [2];
    logic        m_rd   [2];
    logic        m_wr   [2];
    logic [31:0] m_wd   [2];
    logic [3:0]  m_be   [2];
    logic [31:0] s_rdata;
    logic        s_wait;
    logic [1:0]  grant_a;
    logic [1:0]  grant_b;

    int n_vec = 0;
    int n_err = 0;

    mips_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_m0 ();
    mips_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_m1 ();
    mips_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_s  ();
    mips_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_m0 ();
    mips_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_m1 ();
    mips_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_s  ();

    assign a_m0.address = m_addr[0];  assign b_m0.address = m_addr[0];
    assign a_m0.read    = m_rd[0];    assign b_m0.read    = m_rd[0];
    assign a_m0.write   = m_wr[0];    assign b_m0.write   = m_wr[0];
    assign a_m0.writedata  = m_wd[0]; assign b_m0.writedata  = m_wd[0];
    assign a_m0.byteenable = m_be[0]; assign b_m0.byteenable = m_be[0];
    assign a_m1.address = m_addr[1];  assign b_m1.address = m_addr[1];
    assign a_m1.read    = m_rd[1];    assign b_m1.read    = m_rd[1];
    assign a_m1.write   = m_wr[1];    assign b_m1.write   = m_wr[1];
    assign a_m1.writedata  = m_wd[1]; assign b_m1.writedata  = m_wd[1];
    assign a_m1.byteenable = m_be[1]; assign b_m1.byteenable = m_be[1];
    assign a_s.readdata    = s_rdata; assign b_s.readdata    = s_rdata;
    assign a_s.waitrequest = s_wait;  assign b_s.waitrequest = s_wait;

    mips_bus_arbiter #(.BURST_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .m0(a_m0), .m1(a_m1), .s(a_s), .grant(grant_a)
    );

    mips_bus_arbiter #(.BURST_MAX(1), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clk(clk), .reset(reset), .m0(b_m0), .m1(b_m1), .s(b_s), .grant(grant_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  grant;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        wq0;
        logic        wq1;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
    } obs_t;

    function automatic obs_t observe(input int k);
        obs_t o;
        if (k == 0) begin
            o.grant = grant_a; o.rd = a_s.read; o.wr = a_s.write; o.addr = a_s.address;
            o.wd = a_s.writedata; o.be = a_s.byteenable; o.wq0 = a_m0.waitrequest;
            o.wq1 = a_m1.waitrequest; o.rdata0 = a_m0.readdata; o.rdata1 = a_m1.readdata;
        end else begin
            o.grant = grant_b; o.rd = b_s.read; o.wr = b_s.write; o.addr = b_s.address;
            o.wd = b_s.writedata; o.be = b_s.byteenable; o.wq0 = b_m0.waitrequest;
            o.wq1 = b_m1.waitrequest; o.rdata0 = b_m0.readdata; o.rdata1 = b_m1.readdata;
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr, input logic [31:0] a);
        m_rd[i] = rd; m_wr[i] = wr; m_addr[i] = a;
    endtask

    // ---------------- reference model: owner index, last served, run length ----------------
    int mo [2];
    int ml [2];
    int mc [2];
    int bm [2] = '{4, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mo[k] = -1; ml[k] = 1; mc[k] = 0;
        end
    endtask

    task automatic check_model(input int k);
        obs_t        o;
        int          h;
        logic [1:0]  eg;
        logic        erd, ewr, ew0, ew1;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        o = observe(k);
        h = mo[k];
        if (h < 0) begin
            eg = 2'b00; erd = 1'b0; ewr = 1'b0; ea = '0; ewd = '0; ebe = '0;
            ew0 = 1'b1; ew1 = 1'b1;
        end else begin
            eg  = (h == 0) ? 2'b01 : 2'b10;
            erd = m_rd[h]; ewr = m_wr[h]; ea = m_addr[h]; ewd = m_wd[h]; ebe = m_be[h];
            ew0 = (h == 0) ? s_wait : 1'b1;
            ew1 = (h == 1) ? s_wait : 1'b1;
        end
        chk($sformatf("rnd%0d grant", k),  32'(o.grant), 32'(eg));
        chk($sformatf("rnd%0d s_read", k), 32'(o.rd), 32'(erd));
        chk($sformatf("rnd%0d s_write", k), 32'(o.wr), 32'(ewr));
        chk($sformatf("rnd%0d s_address", k), o.addr, ea);
        chk($sformatf("rnd%0d s_writedata", k), o.wd, ewd);
        chk($sformatf("rnd%0d s_byteenable", k), 32'(o.be), 32'(ebe));
        chk($sformatf("rnd%0d m0_waitrequest", k), 32'(o.wq0), 32'(ew0));
        chk($sformatf("rnd%0d m1_waitrequest", k), 32'(o.wq1), 32'(ew1));
        chk($sformatf("rnd%0d m0_readdata", k), o.rdata0, s_rdata);
        chk($sformatf("rnd%0d m1_readdata", k), o.rdata1, s_rdata);
    endtask

    task automatic model_step(input int k);
        int rq [2];
        int h, oth;
        rq[0] = (m_rd[0] | m_wr[0]) ? 1 : 0;
        rq[1] = (m_rd[1] | m_wr[1]) ? 1 : 0;
        if (reset) begin
            mo[k] = -1; ml[k] = 1; mc[k] = 0;
        end else if (mo[k] < 0) begin
            if (rq[0] != 0 && rq[1] != 0) mo[k] = 1 - ml[k];
            else if (rq[0] != 0)          mo[k] = 0;
            else if (rq[1] != 0)          mo[k] = 1;
            mc[k] = 0;
        end else begin
            h = mo[k];
            oth = 1 - h;
            if (rq[h] == 0) begin
                ml[k] = h; mc[k] = 0;
                mo[k] = (rq[oth] != 0) ? oth : -1;
            end else if (!s_wait) begin
                if (rq[oth] != 0 && mc[k] + 1 >= bm[k]) begin
                    mo[k] = oth; ml[k] = h; mc[k] = 0;
                end else begin
                    mc[k] = (mc[k] + 1 > 255) ? 255 : mc[k] + 1;
                end
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0;
        logic        r1, w1;
        logic [31:0] a1;
        logic        sw;
        logic [1:0]  g;
        logic        srd, swr;
        logic [31:0] sa;
        logic        wq0, wq1;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                                input logic r1, input logic w1, input logic [31:0] a1, input logic sw,
                                input logic [1:0] g, input logic srd, input logic swr,
                                input logic [31:0] sa, input logic wq0, input logic wq1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
        v.sw = sw; v.g = g; v.srd = srd; v.swr = swr; v.sa = sa; v.wq0 = wq0; v.wq1 = wq1;
        return v;
    endfunction

    vec_t tv [14];

    initial begin
        obs_t o;
        logic [1:0] eg;
        int n0, n1;

        tv[0]  = mk(0, 0,0,32'h0,   0,0,32'h0,   0, 2'b00, 0,0,32'h0,   1,1);
        tv[1]  = mk(0, 1,0,32'h100, 0,0,32'h0,   1, 2'b00, 0,0,32'h0,   1,1);
        tv[2]  = mk(0, 1,0,32'h100, 0,0,32'h0,   1, 2'b01, 1,0,32'h100, 1,1);
        tv[3]  = mk(0, 1,0,32'h100, 0,0,32'h0,   1, 2'b01, 1,0,32'h100, 1,1);
        tv[4]  = mk(0, 1,0,32'h100, 0,0,32'h0,   1, 2'b01, 1,0,32'h100, 1,1);
        tv[5]  = mk(0, 1,0,32'h100, 0,0,32'h0,   0, 2'b01, 1,0,32'h100, 0,1);
        tv[6]  = mk(0, 0,0,32'h0,   0,0,32'h0,   0, 2'b01, 0,0,32'h0,   0,1);
        tv[7]  = mk(0, 0,0,32'h0,   0,0,32'h0,   0, 2'b00, 0,0,32'h0,   1,1);
        tv[8]  = mk(0, 0,0,32'h0,   0,1,32'h200, 1, 2'b00, 0,0,32'h0,   1,1);
        tv[9]  = mk(0, 0,0,32'h0,   0,1,32'h200, 1, 2'b10, 0,1,32'h200, 1,1);
        tv[10] = mk(1, 0,0,32'h0,   0,1,32'h200, 1, 2'b10, 0,1,32'h200, 1,1);
        tv[11] = mk(0, 0,0,32'h0,   0,1,32'h200, 1, 2'b00, 0,0,32'h0,   1,1);
        tv[12] = mk(0, 0,0,32'h0,   0,0,32'h0,   0, 2'b10, 0,0,32'h0,   1,0);
        tv[13] = mk(0, 0,0,32'h0,   0,0,32'h0,   0, 2'b00, 0,0,32'h0,   1,1);

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_wd[i] = '0; m_be[i] = 4'hF;
        end
        s_rdata = 32'hDEADBEEF;
        s_wait  = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 14; i++) begin
            reset = tv[i].rst;
            set_req(0, tv[i].r0, tv[i].w0, tv[i].a0);
            set_req(1, tv[i].r1, tv[i].w1, tv[i].a1);
            s_wait = tv[i].sw;
            @(negedge clk);
            o = observe(0);
            chk($sformatf("tbl%0d grant", i), 32'(o.grant), 32'(tv[i].g));
            chk($sformatf("tbl%0d s_read", i), 32'(o.rd), 32'(tv[i].srd));
            chk($sformatf("tbl%0d s_write", i), 32'(o.wr), 32'(tv[i].swr));
            chk($sformatf("tbl%0d s_address", i), o.addr, tv[i].sa);
            chk($sformatf("tbl%0d m0_waitrequest", i), 32'(o.wq0), 32'(tv[i].wq0));
            chk($sformatf("tbl%0d m1_waitrequest", i), 32'(o.wq1), 32'(tv[i].wq1));
            if (!tv[i].wq0 && tv[i].r0)
                chk($sformatf("tbl%0d m0_readdata", i), o.rdata0, 32'hDEADBEEF);
            tick();
        end

        // Tie from reset, BURST_MAX=1 instance alternates after every completion.
        reset = 1'b1; set_req(0, 0, 0, 0); set_req(1, 0, 0, 0); s_wait = 1'b0;
        tick();
        reset = 1'b0;
        set_req(0, 1, 0, 32'h10); set_req(1, 1, 0, 32'h20);
        @(negedge clk); chk("tie c0 grant", 32'(grant_b), 32'h0); tick();
        @(negedge clk); chk("tie c1 grant", 32'(grant_b), 32'h1);
        chk("tie c1 addr", b_s.address, 32'h10);
        chk("tie c1 m0_wait", 32'(b_m0.waitrequest), 32'h0); tick();
        @(negedge clk); chk("tie c2 grant", 32'(grant_b), 32'h2);
        chk("tie c2 addr", b_s.address, 32'h20);
        chk("tie c2 b4 grant", 32'(grant_a), 32'h1); tick();
        @(negedge clk); chk("tie c3 grant", 32'(grant_b), 32'h1); tick();

        // Streaming writes with BURST_MAX=4: runs of four, no bubbles.
        reset = 1'b1; set_req(0, 0, 0, 0); set_req(1, 0, 0, 0); s_wait = 1'b0;
        tick();
        reset = 1'b0;
        n0 = 0; n1 = 0;
        set_req(0, 0, 1, 32'h1000); set_req(1, 0, 1, 32'h2000);
        @(negedge clk); chk("stream idle grant", 32'(grant_a), 32'h0); tick();
        for (int k = 0; k < 12; k++) begin
            eg = (((k / 4) % 2) == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("stream%0d grant", k), 32'(grant_a), 32'(eg));
            chk($sformatf("stream%0d s_write", k), 32'(a_s.write), 32'h1);
            chk($sformatf("stream%0d s_address", k), a_s.address,
                (eg == 2'b01) ? 32'h1000 + 32'(4 * n0) : 32'h2000 + 32'(4 * n1));
            if (eg == 2'b01) n0++; else n1++;
            tick();
            m_addr[0] = 32'h1000 + 32'(4 * n0);
            m_addr[1] = 32'h2000 + 32'(4 * n1);
        end

        // Stalled m1 keeps the bus while m0 waits; then m1 drops its request.
        reset = 1'b1; set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        tick();
        reset = 1'b0;
        set_req(1, 1, 0, 32'h300); s_wait = 1'b1;
        @(negedge clk); chk("stall c0 grant", 32'(grant_a), 32'h0); tick();
        set_req(0, 1, 0, 32'h400);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("stall c%0d grant", k), 32'(grant_a), 32'h2);
            chk($sformatf("stall c%0d addr", k), a_s.address, 32'h300);
            chk($sformatf("stall c%0d m0_wait", k), 32'(a_m0.waitrequest), 32'h1);
            tick();
        end
        s_wait = 1'b0;
        @(negedge clk); chk("stall c5 grant", 32'(grant_a), 32'h2);
        chk("stall c5 m1_wait", 32'(a_m1.waitrequest), 32'h0); tick();
        set_req(1, 0, 0, 32'h0);
        @(negedge clk); chk("stall c6 grant", 32'(grant_a), 32'h2);
        chk("stall c6 s_read", 32'(a_s.read), 32'h0); tick();
        @(negedge clk); chk("stall c7 grant", 32'(grant_a), 32'h1);
        chk("stall c7 addr", a_s.address, 32'h400); tick();

        // Randomized run against the reference model, both instances.
        reset = 1'b1; set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        tick();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 99) < 25) begin
                    int kind;
                    kind = $urandom_range(0, 7);
                    m_rd[i]   = (kind == 1 || kind == 2 || kind == 7);
                    m_wr[i]   = (kind == 3 || kind == 4 || kind == 7);
                    m_addr[i] = $urandom;
                    m_wd[i]   = $urandom;
                    m_be[i]   = 4'($urandom_range(0, 15));
                end
            end
            s_wait  = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            @(negedge clk);
            check_model(0);
            check_model(1);
            model_step(0);
            model_step(1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master Avalon-MM arbiter that shares one memory port between the CPU bus interface (master 0) and a second requester such as a loader or DMA engine (master 1). It sits between the masters' bus ports and the single memory slave. It grants the bus round-robin, holds the grant for the whole of a waitrequest-stalled transfer, and caps back-to-back transfers per grant so the other master cannot be starved.

## Interface
- BURST_MAX, 4: maximum consecutive completed transfers per grant while the other master is waiting; range 1..255.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- clk  input  1  clock. Reset is reset, synchronous, active-high; clock clk.
- reset  input  1  synchronous active-high reset.
- m0_address / m1_address  input  ADDR_W  master address.
- m0_read / m1_read  input  1  read request.
- m0_write / m1_write  input  1  write request.
- m0_writedata / m1_writedata  input  DATA_W  write data.
- m0_byteenable / m1_byteenable  input  DATA_W/8  byte lanes.
- m0_readdata / m1_readdata  output  DATA_W  read data; both are wired to s_readdata.
- m0_waitrequest / m1_waitrequest  output  1  stall to the master.
- s_address  output  ADDR_W  to slave.
- s_read, s_write  output  1  to slave.
- s_writedata  output  DATA_W  to slave.
- s_byteenable  output  DATA_W/8  to slave.
- s_readdata  input  DATA_W  from slave.
- s_waitrequest  input  1  from slave.
- grant  output  2  one-hot current owner; 00 when idle (debug/observability).

## Operation
- A master requests when `mI_read | mI_write`. Simultaneous read and write are forwarded unchanged and are not checked.
- FSM states are IDLE, GNT0 and GNT1. There is also a `last` flag (the last master served) and a `cnt` counter of 8 bits.
- IDLE:
  - Slave outputs are all zero.
  - Both `mI_waitrequest` are 1.
  - Single requester: go to its GNT state.
  - Both requesting: grant the master that is not `last`.
- GNTi:
  - Slave outputs mirror master i combinationally.
  - `mi_waitrequest = s_waitrequest`; the other master's waitrequest is 1.
- A completion is a cycle in GNTi with master i requesting and `s_waitrequest = 0`. On completion:
  - `cnt` increments.
  - If the other master is requesting and `cnt+1 >= BURST_MAX`, switch to GNTj with `cnt <= 0` and `last <= i`.
  - Otherwise stay in GNTi.
- GNTi with master i not requesting:
  - If the other master is requesting, go to GNTj, else go to IDLE.
  - In both cases `cnt <= 0` and `last <= i`.
- The grant never changes while the holder requests and `s_waitrequest = 1`. That transfer is in flight and its address, data and byteenable stay routed.
- With only one master active, its grant is unbounded and `cnt` saturates at 255.

## Timing
- Reset values: state IDLE, `cnt` 0, `last` = 1 (so master 0 wins the first tie), `grant` 00.
  - Consequently `s_read` = 0, `s_write` = 0, `s_address` = 0, `s_writedata` = 0, `s_byteenable` = 0.
  - Both `mI_waitrequest` = 1.
- Reset asserted mid-transfer: at the next edge the FSM is in IDLE and slave strobes drop. The aborted master keeps seeing waitrequest=1 and must re-present its request.
- Arbitration latency from IDLE is 1 cycle: the request is seen in cycle N and is routed to the slave in cycle N+1.
- Back-to-back transfers by the holder: zero bubble cycles.
- Switch decided at a completion: the new master is routed in the next cycle, with zero bubble.
- Switch because the holder dropped its request: one cycle in which the holder is idle, then the new master is routed.
- Read data is valid to a master exactly in the cycles where its waitrequest is 0 and it is reading.

## Structure
- Package `mips_bus_pkg`:
  - `arb_state_t` enum (IDLE, GNT0, GNT1).
  - `ARB_CNT_W = 8` constant.
- Single module with no sub-module. The per-master muxing is two symmetric `always_comb` branches, and the FSM, `cnt` and `last` live in one `always_ff`.

## Test plan
- Reset, then idle → `grant` = 00, `s_read` = 0, `s_write` = 0, both waitrequests = 1.
- m0 reads 0x100 alone with the slave stalling 3 cycles → `s_address` = 0x100 from cycle 1 onward. `m0_waitrequest` tracks `s_waitrequest`, and readdata 0xDEADBEEF is delivered on the cycle waitrequest drops.
- m0 and m1 both request from IDLE after reset → m0 is granted first. After m0's completion with m1 still waiting and BURST_MAX=1, m1 is granted the next cycle.
- m0 streams 10 writes while m1 requests continuously, BURST_MAX=4 → grant sequence is 4×m0, 4×m1 (m1 issuing 4 writes), then m0 again, with no bubbles.
- m1 is granted with the slave stalling while m0 requests → grant stays with m1 until the stall ends, and `s_address` never shows m0's address mid-stall.
- Reset asserted mid-stall on m1 write 0x200 → `s_write` = 0 the next cycle, `grant` = 00, `m1_waitrequest` = 1.
